// File: rtl/tdm_demux.sv
// Sorts a TDM sample stream (channel 0 flagged by in_sof) into a frame-atomic parallel snapshot.
// Latency: out_data/frame_done update 1 cycle after the last sample; no backpressure, every valid sample is consumed.
module tdm_demux #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 8,
  localparam int CNT_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [DATA_W-1:0]        in_data,
  output logic [CH_NUM*DATA_W-1:0] out_data,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic [CNT_W-1:0]         ch_idx
);

  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CH_NUM - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                    state;
  logic [CH_NUM*DATA_W-1:0] shadow;
  logic [CH_NUM*DATA_W-1:0] merged;

  // Snapshot with the sample being accepted this cycle already in place, so
  // completion publishes the full frame on the same edge that takes the last sample.
  always_comb begin
    merged = shadow;
    merged[ch_idx*DATA_W +: DATA_W] = in_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      ch_idx     <= '0;
      shadow     <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (in_valid) begin
        unique case (state)
          IDLE: begin
            if (in_sof) begin
              shadow[DATA_W-1:0] <= in_data;
              if (CH_NUM == 1) begin
                out_data   <= merged;
                frame_done <= 1'b1;
              end else begin
                ch_idx <= CNT_W'(1);
                state  <= RECV;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          RECV: begin
            if (in_sof) begin
              // Short frame: drop the partial one and restart on this sample.
              frame_err          <= 1'b1;
              shadow[DATA_W-1:0] <= in_data;
              ch_idx             <= CNT_W'(1);
            end else begin
              shadow[ch_idx*DATA_W +: DATA_W] <= in_data;
              if (ch_idx == LAST_CH) begin
                out_data   <= merged;
                frame_done <= 1'b1;
                ch_idx     <= '0;
                state      <= IDLE;
              end else begin
                ch_idx <= ch_idx + CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (CH_NUM=4, DATA_W=8).
module tb_tdm_demux;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  ch_idx;

  int checks   = 0;
  int failures = 0;

  tdm_demux #(.CH_NUM(4), .DATA_W(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_data   (out_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .ch_idx     (ch_idx)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then settle just after the consuming edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 8'h00;
    #3;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_ch_idx", ch_idx, 2'd0);
    #14;
    sys_rst_n = 1'b1;

    // Single frame, consecutive samples
    step(1'b1, 1'b1, 8'hA1);
    chk("f1_ch_idx_a", ch_idx, 2'd1);
    chk("f1_err_a", frame_err, 1'b0);
    step(1'b1, 1'b0, 8'hB2);
    chk("f1_err_b", frame_err, 1'b0);
    step(1'b1, 1'b0, 8'hC3);
    chk("f1_mid_out", out_data, 32'h0);
    chk("f1_mid_done", frame_done, 1'b0);
    chk("f1_ch_idx_c", ch_idx, 2'd3);
    step(1'b1, 1'b0, 8'hD4);
    chk("f1_done", frame_done, 1'b1);
    chk("f1_out", out_data, 32'hD4C3B2A1);
    chk("f1_err_d", frame_err, 1'b0);
    chk("f1_ch_idx_end", ch_idx, 2'd0);
    idle(1);
    chk("f1_done_clr", frame_done, 1'b0);

    // Same frame with 3-cycle gaps between samples
    step(1'b1, 1'b1, 8'hA1);
    idle(3);
    chk("gap_ch_idx_hold", ch_idx, 2'd1);
    step(1'b1, 1'b0, 8'hB2);
    idle(3);
    chk("gap_ch_idx_b", ch_idx, 2'd2);
    chk("gap_no_done", frame_done, 1'b0);
    step(1'b1, 1'b0, 8'hC3);
    idle(3);
    chk("gap_no_done2", frame_done, 1'b0);
    step(1'b1, 1'b0, 8'hD4);
    chk("gap_done", frame_done, 1'b1);
    chk("gap_out", out_data, 32'hD4C3B2A1);
    idle(1);
    chk("gap_single_done", frame_done, 1'b0);

    // Short frame: second sof restarts the frame
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    chk("short_err", frame_err, 1'b1);
    chk("short_no_done", frame_done, 1'b0);
    chk("short_ch_idx", ch_idx, 2'd1);
    chk("short_out_hold", out_data, 32'hD4C3B2A1);
    step(1'b1, 1'b0, 8'h44);
    chk("short_err_clr", frame_err, 1'b0);
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'h66);
    chk("short_done", frame_done, 1'b1);
    chk("short_out", out_data, 32'h66554433);
    chk("short_err_end", frame_err, 1'b0);

    // Stray sample with no sof while idle
    idle(1);
    step(1'b1, 1'b0, 8'h77);
    chk("stray_err", frame_err, 1'b1);
    chk("stray_done", frame_done, 1'b0);
    chk("stray_out", out_data, 32'h66554433);
    chk("stray_ch_idx", ch_idx, 2'd0);
    idle(1);
    chk("stray_err_clr", frame_err, 1'b0);

    // Back-to-back frames
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, 8'h03);
    step(1'b1, 1'b0, 8'h04);
    chk("b2b_done1", frame_done, 1'b1);
    chk("b2b_out1", out_data, 32'h04030201);
    step(1'b1, 1'b1, 8'h05);
    chk("b2b_sof_done_clr", frame_done, 1'b0);
    chk("b2b_sof_err", frame_err, 1'b0);
    chk("b2b_sof_ch_idx", ch_idx, 2'd1);
    step(1'b1, 1'b0, 8'h06);
    step(1'b1, 1'b0, 8'h07);
    chk("b2b_mid_out", out_data, 32'h04030201);
    step(1'b1, 1'b0, 8'h08);
    chk("b2b_done2", frame_done, 1'b1);
    chk("b2b_out2", out_data, 32'h08070605);

    // Async reset mid-frame
    step(1'b1, 1'b1, 8'h0A);
    step(1'b1, 1'b0, 8'h0B);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 8'h00;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_out", out_data, 32'h0);
    chk("arst_ch_idx", ch_idx, 2'd0);
    chk("arst_done", frame_done, 1'b0);
    #2;
    sys_rst_n = 1'b1;
    step(1'b1, 1'b1, 8'h0A);
    chk("post_rst_ch_idx", ch_idx, 2'd1);
    step(1'b1, 1'b0, 8'h0B);
    step(1'b1, 1'b0, 8'h0C);
    chk("post_rst_no_done", frame_done, 1'b0);
    step(1'b1, 1'b0, 8'h0D);
    chk("post_rst_done", frame_done, 1'b1);
    chk("post_rst_out", out_data, 32'h0D0C0B0A);
    chk("post_rst_err", frame_err, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
